// File: rtl/dcache_writeback_sequencer_if.sv
// Handshake bundle between the dcache FSM, the writeback sequencer and the memory port.
// The master modport is the sequencer side.
interface dcache_writeback_sequencer_if #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PLEN       = 34
);
  localparam int unsigned NUM_WORDS = LINE_WIDTH / XLEN;

  logic                  wb_req_i;
  logic [LINE_WIDTH-1:0] wb_line_i;
  logic [PLEN-1:0]       wb_addr_i;
  logic [NUM_WORDS-1:0]  wb_word_dirty_i;
  logic                  wb_ready_o;
  logic                  wb_done_o;

  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [PLEN-1:0]       mem_addr_o;
  logic [XLEN-1:0]       mem_wdata_o;
  logic [2:0]            mem_size_o;
  logic [XLEN/8-1:0]     mem_be_o;
  logic                  mem_rtrn_i;

  modport master (
    input  wb_req_i, wb_line_i, wb_addr_i, wb_word_dirty_i, mem_gnt_i, mem_rtrn_i,
    output wb_ready_o, wb_done_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_size_o, mem_be_o
  );

  modport slave (
    output wb_req_i, wb_line_i, wb_addr_i, wb_word_dirty_i, mem_gnt_i, mem_rtrn_i,
    input  wb_ready_o, wb_done_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_size_o, mem_be_o
  );
endinterface

// File: rtl/dcache_writeback_sequencer.sv
// Drains one captured dirty cache line as word-sized store requests on the memory port.
// Define DCACHE_WB_SKIP_CLEAN_WORDS_EN to send only the words flagged in the dirty mask.
module dcache_writeback_sequencer #(
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PLEN         = 34,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input logic                          clk_i,
  input logic                          rst_i,
  dcache_writeback_sequencer_if.master bus
);
  localparam int unsigned NUM_WORDS  = LINE_WIDTH / XLEN;
  localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned BYTE_SHIFT = $clog2(XLEN / 8);
  localparam logic [PLEN-1:0] OFFSET_MASK = PLEN'((64'd1 << OFFSET_WIDTH) - 64'd1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RTRN} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LINE_WIDTH-1:0] line_q;
  logic [PLEN-1:0]       addr_q;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  word_done;
  logic                  last_word;
  logic [IDX_W-1:0]      next_idx;

`ifdef DCACHE_WB_SKIP_CLEAN_WORDS_EN
  logic [NUM_WORDS-1:0] mask_q;
  logic [IDX_W:0]       first_sel;
  logic [IDX_W:0]       next_sel;

  // Returns {found, index} of the lowest set mask bit at or above start.
  function automatic logic [IDX_W:0] find_dirty(input logic [NUM_WORDS-1:0] mask,
                                                input int unsigned start);
    logic             found;
    logic [IDX_W-1:0] pos;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (!found && k >= start && mask[k]) begin
        found = 1'b1;
        pos   = IDX_W'(k);
      end
    end
    return {found, pos};
  endfunction

  assign first_sel = find_dirty(bus.wb_word_dirty_i, 0);
  assign next_sel  = find_dirty(mask_q, 32'(idx_q) + 32'd1);
  assign last_word = !next_sel[IDX_W];
  assign next_idx  = next_sel[IDX_W-1:0];
`else
  logic unused_dirty;
  assign unused_dirty = ^bus.wb_word_dirty_i;
  assign last_word    = (32'(idx_q) == NUM_WORDS - 1);
  assign next_idx     = idx_q + 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wb_req_i) begin
          accept = 1'b1;
`ifdef DCACHE_WB_SKIP_CLEAN_WORDS_EN
          // A fully clean line completes without touching memory.
          if (first_sel[IDX_W]) begin
            idx_d   = first_sel[IDX_W-1:0];
            state_d = REQ;
          end else begin
            done_d = 1'b1;
          end
`else
          idx_d   = '0;
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          if (bus.mem_rtrn_i) word_done = 1'b1;
          else                state_d   = WAIT_RTRN;
        end
      end
      WAIT_RTRN: begin
        if (bus.mem_rtrn_i) word_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (last_word) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        idx_d   = next_idx;
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      line_q  <= '0;
      addr_q  <= '0;
`ifdef DCACHE_WB_SKIP_CLEAN_WORDS_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (accept) begin
        line_q <= bus.wb_line_i;
        addr_q <= bus.wb_addr_i & ~OFFSET_MASK;
`ifdef DCACHE_WB_SKIP_CLEAN_WORDS_EN
        mask_q <= bus.wb_word_dirty_i;
`endif
      end
    end
  end

  assign bus.wb_ready_o  = (state_q == IDLE);
  assign bus.wb_done_o   = done_q;
  assign bus.mem_req_o   = (state_q == REQ);
  assign bus.mem_addr_o  = addr_q + (PLEN'(idx_q) << BYTE_SHIFT);
  assign bus.mem_wdata_o = line_q[idx_q*XLEN +: XLEN];
  assign bus.mem_size_o  = 3'b010;
  assign bus.mem_be_o    = '1;
endmodule

// File: tb/tb_dcache_writeback_sequencer.sv
// Scoreboard bench: stimulus queues expected stores/done pulses, a monitor checks them.
// A scripted memory responder models grant stalls, same-cycle returns and dropped returns.
module tb_dcache_writeback_sequencer;
  localparam int unsigned LW = 128;
  localparam int unsigned XL = 32;
  localparam int unsigned PL = 34;
  localparam int unsigned NW = LW / XL;

  typedef struct {
    int            cyc;
    logic [PL-1:0] addr;
    logic [XL-1:0] data;
  } req_t;

  logic clk, rst;
  int   cyc, n_checks, n_fail;
  req_t exp_q[$];
  int   done_q[$];
  int   stall_word, stall_len, drop_word, test_id;
  bit   same_cycle, stray_rtrn;
  int   t0;

`ifdef DCACHE_WB_SKIP_CLEAN_WORDS_EN
  localparam logic [NW-1:0] ALL = '1;
`else
  localparam logic [NW-1:0] ALL = '0;  // mask must be ignored in this build
`endif

  localparam logic [LW-1:0] LINE1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [LW-1:0] LINE2 = 128'h0F0F0F0F_12345678_9ABCDEF0_55555555;
  localparam logic [LW-1:0] LINEA = 128'h44444444_33333333_22222222_11111111;
  localparam logic [LW-1:0] LINEB = 128'h88888888_77777777_66666666_55555555;

  dcache_writeback_sequencer_if #(.LINE_WIDTH(LW), .XLEN(XL), .PLEN(PL)) bus ();

  dcache_writeback_sequencer #(
    .LINE_WIDTH(LW), .XLEN(XL), .PLEN(PL), .OFFSET_WIDTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_req(input int c, input logic [PL-1:0] a, input logic [XL-1:0] d);
    req_t r;
    r.cyc  = c;
    r.addr = a;
    r.data = d;
    exp_q.push_back(r);
  endtask

  task automatic cfg(input int sw, input int sl, input bit sc, input int dw);
    stall_word = sw;
    stall_len  = sl;
    same_cycle = sc;
    drop_word  = dw;
    test_id++;
  endtask

  // Called at a negedge; accept happens at the following posedge.
  task automatic drive(input logic [LW-1:0] line, input logic [PL-1:0] addr, input logic [NW-1:0] mask);
    bus.wb_line_i       = line;
    bus.wb_addr_i       = addr;
    bus.wb_word_dirty_i = mask;
    bus.wb_req_i        = 1'b1;
    @(negedge clk);
    bus.wb_req_i        = 1'b0;
    bus.wb_line_i       = {4{32'hBAD0_BAD0}};
    bus.wb_addr_i       = '1;
    bus.wb_word_dirty_i = ~mask;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || done_q.size() != 0); i++) @(negedge clk);
    check("drain", 64'(exp_q.size() + done_q.size()), 64'd0);
    exp_q.delete();
    done_q.delete();
  endtask

  // Memory responder: decides grant/return for each cycle at the negedge.
  initial begin
    int   gcnt, seen, left;
    bit   pend;
    logic g, r;
    gcnt = 0; seen = 0; left = 0; pend = 0;
    bus.mem_gnt_i  = 1'b0;
    bus.mem_rtrn_i = 1'b0;
    forever begin
      @(negedge clk);
      if (seen != test_id) begin
        seen = test_id; gcnt = 0; pend = 0; left = stall_len;
      end
      g = 1'b0;
      r = 1'b0;
      if (pend) begin r = 1'b1; pend = 0; end
      if (stray_rtrn) r = 1'b1;
      if (bus.mem_req_o === 1'b1) begin
        if (left > 0 && gcnt == stall_word) left--;
        else begin
          g = 1'b1;
          if (same_cycle) r = 1'b1;
          else if (gcnt != drop_word) pend = 1;
          gcnt++;
        end
      end
      bus.mem_gnt_i  = g;
      bus.mem_rtrn_i = r;
    end
  end

  // Monitor: compares presented requests and done pulses against the queues.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.mem_req_o !== 1'b0) begin
        if (exp_q.size() == 0) check("unexpected_req", 64'(bus.mem_req_o), 64'd0);
        else begin
          check("req_addr", 64'(bus.mem_addr_o), 64'(exp_q[0].addr));
          check("req_data", 64'(bus.mem_wdata_o), 64'(exp_q[0].data));
          check("req_size", 64'(bus.mem_size_o), 64'd2);
          check("req_be", 64'(bus.mem_be_o), 64'hF);
          if (bus.mem_gnt_i) begin
            check("gnt_cycle", 64'(cyc), 64'(exp_q[0].cyc));
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.wb_done_o !== 1'b0) begin
        if (done_q.size() == 0) check("unexpected_done", 64'(bus.wb_done_o), 64'd0);
        else begin
          check("done_cycle", 64'(cyc), 64'(done_q[0]));
          check("ready_at_done", 64'(bus.wb_ready_o), 64'd1);
          void'(done_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; test_id = 0; stray_rtrn = 0;
    cfg(-1, 0, 0, -1);
    rst = 1'b1;
    bus.wb_req_i = 1'b0; bus.wb_line_i = '0; bus.wb_addr_i = '0; bus.wb_word_dirty_i = '0;
    #1;
    check("rst_ready", 64'(bus.wb_ready_o), 64'd1);
    check("rst_done", 64'(bus.wb_done_o), 64'd0);
    check("rst_req", 64'(bus.mem_req_o), 64'd0);
    check("rst_addr", 64'(bus.mem_addr_o), 64'd0);
    check("rst_wdata", 64'(bus.mem_wdata_o), 64'd0);
    check("rst_size", 64'(bus.mem_size_o), 64'd2);
    check("rst_be", 64'(bus.mem_be_o), 64'hF);
    @(negedge clk);
    rst = 1'b0;

    // Basic line writeback, grant immediately, return next cycle.
    cfg(-1, 0, 0, -1);
    @(negedge clk); t0 = cyc;
    exp_req(t0+1, 34'h0_8000_0010, 32'hAAAAAAAA);
    exp_req(t0+3, 34'h0_8000_0014, 32'hBBBBBBBB);
    exp_req(t0+5, 34'h0_8000_0018, 32'hCCCCCCCC);
    exp_req(t0+7, 34'h0_8000_001C, 32'hDDDDDDDD);
    done_q.push_back(t0+9);
    drive(LINE1, 34'h0_8000_0014, ALL);
    #1;
    check("busy_ready", 64'(bus.wb_ready_o), 64'd0);
    check("first_req", 64'(bus.mem_req_o), 64'd1);
    wait_drain();

    // Grant withheld for 5 cycles on word 1.
    cfg(1, 5, 0, -1);
    @(negedge clk); t0 = cyc;
    exp_req(t0+1,  34'h1_2345_6780, 32'h55555555);
    exp_req(t0+8,  34'h1_2345_6784, 32'h9ABCDEF0);
    exp_req(t0+10, 34'h1_2345_6788, 32'h12345678);
    exp_req(t0+12, 34'h1_2345_678C, 32'h0F0F0F0F);
    done_q.push_back(t0+14);
    drive(LINE2, 34'h1_2345_6788, ALL);
    wait_drain();

    // Grant and return in the same cycle for every word.
    cfg(-1, 0, 1, -1);
    @(negedge clk); t0 = cyc;
    exp_req(t0+1, 34'h0_0000_0100, 32'hAAAAAAAA);
    exp_req(t0+2, 34'h0_0000_0104, 32'hBBBBBBBB);
    exp_req(t0+3, 34'h0_0000_0108, 32'hCCCCCCCC);
    exp_req(t0+4, 34'h0_0000_010C, 32'hDDDDDDDD);
    done_q.push_back(t0+5);
    drive(LINE1, 34'h0_0000_0100, ALL);
    wait_drain();

    // Back-to-back: second request held while busy, accepted in the done cycle.
    cfg(-1, 0, 0, -1);
    @(negedge clk); t0 = cyc;
    exp_req(t0+1,  34'h0_0000_1000, 32'h11111111);
    exp_req(t0+3,  34'h0_0000_1004, 32'h22222222);
    exp_req(t0+5,  34'h0_0000_1008, 32'h33333333);
    exp_req(t0+7,  34'h0_0000_100C, 32'h44444444);
    done_q.push_back(t0+9);
    exp_req(t0+10, 34'h2_0000_0040, 32'h55555555);
    exp_req(t0+12, 34'h2_0000_0044, 32'h66666666);
    exp_req(t0+14, 34'h2_0000_0048, 32'h77777777);
    exp_req(t0+16, 34'h2_0000_004C, 32'h88888888);
    done_q.push_back(t0+18);
    drive(LINEA, 34'h0_0000_1000, ALL);
    while (cyc < t0 + 4) @(negedge clk);
    bus.wb_line_i = LINEB; bus.wb_addr_i = 34'h2_0000_004C; bus.wb_word_dirty_i = ALL;
    bus.wb_req_i  = 1'b1;
    while (cyc < t0 + 10) @(negedge clk);
    bus.wb_req_i  = 1'b0;
    wait_drain();

    // Reset while waiting for word 2's return; a stray return afterward is ignored.
    cfg(-1, 0, 0, 2);
    @(negedge clk); t0 = cyc;
    exp_req(t0+1, 34'h0_8000_0010, 32'hAAAAAAAA);
    exp_req(t0+3, 34'h0_8000_0014, 32'hBBBBBBBB);
    exp_req(t0+5, 34'h0_8000_0018, 32'hCCCCCCCC);
    drive(LINE1, 34'h0_8000_0014, ALL);
    while (cyc < t0 + 7) @(negedge clk);
    check("pre_reset_ready", 64'(bus.wb_ready_o), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(bus.wb_ready_o), 64'd1);
    check("mid_rst_done", 64'(bus.wb_done_o), 64'd0);
    check("mid_rst_req", 64'(bus.mem_req_o), 64'd0);
    check("mid_rst_addr", 64'(bus.mem_addr_o), 64'd0);
    check("mid_rst_wdata", 64'(bus.mem_wdata_o), 64'd0);
    wait_drain();
    #2 rst = 1'b0;
    @(posedge clk); #1 stray_rtrn = 1;
    @(posedge clk); #1 stray_rtrn = 0;
    repeat (3) @(negedge clk);
    #1;
    check("stray_done", 64'(bus.wb_done_o), 64'd0);
    check("stray_ready", 64'(bus.wb_ready_o), 64'd1);

`ifdef DCACHE_WB_SKIP_CLEAN_WORDS_EN
    // Only dirty words 1 and 3 are written.
    cfg(-1, 0, 0, -1);
    @(negedge clk); t0 = cyc;
    exp_req(t0+1, 34'h0_8000_0014, 32'hBBBBBBBB);
    exp_req(t0+3, 34'h0_8000_001C, 32'hDDDDDDDD);
    done_q.push_back(t0+5);
    drive(LINE1, 34'h0_8000_0014, 4'b1010);
    wait_drain();

    // Fully clean line: done next cycle, no memory traffic.
    cfg(-1, 0, 0, -1);
    @(negedge clk); t0 = cyc;
    done_q.push_back(t0+1);
    drive(LINE1, 34'h0_8000_0014, 4'b0000);
    wait_drain();
    repeat (2) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
